commit_trace_buffer: RTL

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

---
 rtl/trace_pkg.sv | 28 ++
 rtl/commit_trace_buffer_if.sv | 43 ++++
 rtl/trace_fifo_2w1r.sv | 64 ++++++
 rtl/commit_trace_buffer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Package : trace_pkg
// Desc    : Shared trace record layout and default sizing for the trace buffer.
// Rev     : 1.0  initial release
// ============================================================================
package trace_pkg;

  localparam int unsigned NR_COMMIT_PORTS_DEFAULT = 2;
  localparam int unsigned DEPTH_DEFAULT           = 8;
  localparam int unsigned CNT_W_DEFAULT           = 16;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [63:0] wdata;
    logic        we_gpr;
    logic        we_fpr;
    logic [1:0]  priv;
    logic        debug;
    logic        is_exc;
    logic [63:0] cause;
    logic [63:0] tval;
  } trace_rec_t;

endpackage
`default_nettype wire

// File: rtl/commit_trace_buffer_if.sv
`default_nettype none
// ============================================================================
// Module  : commit_trace_buffer_if
// Desc    : Commit-port sampling bus plus the trace record output stream.
// Rev     : 1.0  initial release
// ============================================================================
interface commit_trace_buffer_if #(
  parameter int unsigned NR_COMMIT_PORTS = 2
);
  import trace_pkg::*;

  logic [NR_COMMIT_PORTS-1:0]       commit_ack_i;
  logic [NR_COMMIT_PORTS-1:0][63:0] commit_pc_i;
  logic [NR_COMMIT_PORTS-1:0][31:0] commit_instr_i;
  logic [NR_COMMIT_PORTS-1:0]       we_gpr_i;
  logic [NR_COMMIT_PORTS-1:0]       we_fpr_i;
  logic [NR_COMMIT_PORTS-1:0][4:0]  waddr_i;
  logic [NR_COMMIT_PORTS-1:0][63:0] wdata_i;
  logic [1:0]                       priv_lvl_i;
  logic                             debug_mode_i;
  logic                             ex_valid_i;
  logic [63:0]                      ex_cause_i;
  logic [63:0]                      ex_tval_i;
  logic                             trace_valid_o;
  logic                             trace_ready_i;
  trace_rec_t                       trace_o;

  modport master (
    output commit_ack_i, commit_pc_i, commit_instr_i, we_gpr_i, we_fpr_i,
           waddr_i, wdata_i, priv_lvl_i, debug_mode_i, ex_valid_i,
           ex_cause_i, ex_tval_i, trace_ready_i,
    input  trace_valid_o, trace_o
  );

  modport slave (
    input  commit_ack_i, commit_pc_i, commit_instr_i, we_gpr_i, we_fpr_i,
           waddr_i, wdata_i, priv_lvl_i, debug_mode_i, ex_valid_i,
           ex_cause_i, ex_tval_i, trace_ready_i,
    output trace_valid_o, trace_o
  );

endinterface
`default_nettype wire

// File: rtl/trace_fifo_2w1r.sv
`default_nettype none
// ============================================================================
// Module  : trace_fifo_2w1r
// Desc    : Record FIFO, compacted multi-lane write, single read, level count.
// Rev     : 1.0  initial release
// ============================================================================
module trace_fifo_2w1r
  import trace_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEFAULT,
  parameter  int unsigned NW    = 2,
  localparam int unsigned C_AW  = $clog2(DEPTH),
  localparam int unsigned C_LW  = C_AW + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic [C_LW-1:0]     push_n_i,
  input  trace_rec_t [NW-1:0] wr_data_i,
  input  logic                pop_i,
  output logic                valid_o,
  output trace_rec_t          rd_data_o,
  output logic [C_LW-1:0]     level_o
);

  trace_rec_t      r_mem [DEPTH];
  logic [C_AW-1:0] r_wptr;
  logic [C_AW-1:0] r_rptr;
  logic [C_LW-1:0] r_level;
  logic            w_pop;

  assign w_pop = pop_i & (r_level != '0);

  // Lanes arrive compacted: lane k lands k slots past the write pointer.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NW; k++) begin
      if (C_LW'(k) < push_n_i) begin
        r_mem[r_wptr + C_AW'(k)] <= wr_data_i[k];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      r_wptr  <= r_wptr + C_AW'(push_n_i);
      r_rptr  <= r_rptr + C_AW'(w_pop);
      r_level <= r_level + push_n_i - C_LW'(w_pop);
    end
  end

  assign valid_o   = (r_level != '0);
  assign rd_data_o = r_mem[r_rptr];
  assign level_o   = r_level;

endmodule
`default_nettype wire

// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module  : commit_trace_buffer
// Desc    : Captures retiring instructions into a trace FIFO with drop counting.
// Rev     : 1.0  initial release
// ============================================================================
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter  int unsigned NR_COMMIT_PORTS = NR_COMMIT_PORTS_DEFAULT,
  parameter  int unsigned DEPTH           = DEPTH_DEFAULT,
  parameter  int unsigned CNT_W           = CNT_W_DEFAULT,
  localparam int unsigned C_LW            = $clog2(DEPTH) + 1,
  localparam int unsigned C_DW            = $clog2(NR_COMMIT_PORTS + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        enable_i,
  input  logic                        flush_i,
  input  logic                        clear_i,
  commit_trace_buffer_if.slave        trace_bus,
  output logic [CNT_W-1:0]            drop_cnt_o,
  output logic                        overflow_o,
  output logic [C_LW-1:0]             level_o
);

  trace_rec_t                       w_rec  [NR_COMMIT_PORTS];
  logic [C_LW-1:0]                  w_rank [NR_COMMIT_PORTS];
  logic [NR_COMMIT_PORTS-1:0]       w_req;
  logic [NR_COMMIT_PORTS-1:0]       w_acc;
  trace_rec_t [NR_COMMIT_PORTS-1:0] w_lane;
  logic [C_LW-1:0]                  w_free;
  logic [C_LW-1:0]                  w_push_n;
  logic [C_LW-1:0]                  w_level;
  logic [C_DW-1:0]                  w_drop_n;
  logic                             w_cap;
  logic                             w_pop;
  logic                             w_valid;
  trace_rec_t                       w_head;
  logic [CNT_W:0]                   w_sum;
  logic [CNT_W-1:0]                 r_drop_cnt;
  logic                             r_ovf;

  assign w_cap  = enable_i & ~flush_i;
  assign w_pop  = trace_bus.trace_ready_i & w_valid & ~flush_i;
  assign w_free = C_LW'(DEPTH) - w_level;

  always_comb begin
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      w_rec[i]        = '0;
      w_rec[i].pc     = trace_bus.commit_pc_i[i];
      w_rec[i].instr  = trace_bus.commit_instr_i[i];
      w_rec[i].rd     = trace_bus.waddr_i[i];
      w_rec[i].wdata  = trace_bus.wdata_i[i];
      w_rec[i].we_gpr = trace_bus.we_gpr_i[i] & trace_bus.commit_ack_i[i];
      w_rec[i].we_fpr = trace_bus.we_fpr_i[i] & trace_bus.commit_ack_i[i];
      w_rec[i].priv   = trace_bus.priv_lvl_i;
      w_rec[i].debug  = trace_bus.debug_mode_i;
      w_req[i]        = trace_bus.commit_ack_i[i];
    end
    // A trap still produces a port-0 record even without an ack there.
    if (trace_bus.ex_valid_i) begin
      w_req[0]        = 1'b1;
      w_rec[0].is_exc = 1'b1;
      w_rec[0].cause  = trace_bus.ex_cause_i;
      w_rec[0].tval   = trace_bus.ex_tval_i;
    end
  end

  // Lowest ports claim free slots first; a same-cycle pop frees nothing yet.
  always_comb begin
    w_push_n = '0;
    w_drop_n = '0;
    w_acc    = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      w_rank[i] = w_push_n;
      if (w_cap && w_req[i]) begin
        if (w_push_n < w_free) begin
          w_acc[i] = 1'b1;
          w_push_n = w_push_n + C_LW'(1);
        end else begin
          w_drop_n = w_drop_n + C_DW'(1);
        end
      end
    end
  end

  always_comb begin
    w_lane = '0;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
        if (w_acc[i] && (w_rank[i] == C_LW'(k))) begin
          w_lane[k] = w_rec[i];
        end
      end
    end
  end

  trace_fifo_2w1r #(
    .DEPTH (DEPTH),
    .NW    (NR_COMMIT_PORTS)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (flush_i),
    .push_n_i  (w_push_n),
    .wr_data_i (w_lane),
    .pop_i     (w_pop),
    .valid_o   (w_valid),
    .rd_data_o (w_head),
    .level_o   (w_level)
  );

  assign w_sum = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_drop_n);

  // A drop in the same cycle as clear restarts the count at this drop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_drop_cnt <= '0;
      r_ovf      <= 1'b0;
    end else if (w_drop_n != '0) begin
      r_ovf <= 1'b1;
      if (clear_i) begin
        r_drop_cnt <= CNT_W'(w_drop_n);
      end else if (w_sum[CNT_W]) begin
        r_drop_cnt <= '1;
      end else begin
        r_drop_cnt <= w_sum[CNT_W-1:0];
      end
    end else if (clear_i) begin
      r_drop_cnt <= '0;
      r_ovf      <= 1'b0;
    end
  end

  assign trace_bus.trace_valid_o = w_valid;
  assign trace_bus.trace_o       = w_head;
  assign drop_cnt_o              = r_drop_cnt;
  assign overflow_o              = r_ovf;
  assign level_o                 = w_level;

endmodule
`default_nettype wire
